exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have exactly one clock domain and one reset; the port widths are fixed and it has no parameters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 freeze  input  1  memory-stall hold; while high, all stage registers keep their value.
REQ-005 exe_cmd  input  4  ALU opcode: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
REQ-006 wb_en_in, mem_r_en_in, mem_w_en_in, s_bit, b  input  1 each  control bits from ID/EX.
REQ-007 pc  input  32  PC+4 of the instruction.
REQ-008 val_rn, val_rm, val2  input  32 each  operand 1, store data and shifter operand (val2 is precomputed upstream).
REQ-009 signed_imm_24  input  24  branch offset, in words.
REQ-010 dest_in  input  4  destination register.
REQ-011 sel_src1, sel_src2  input  2 each  forwarding selects: 00 register, 01 MEM-stage value, 10 WB-stage value, 11 register.
REQ-012 mem_fwd_val, wb_fwd_val  input  32 each  forwarded values.
REQ-013 alu_res, st_val  output  32 each  registered ALU result and store data.
REQ-014 dest, wb_en, mem_r_en, mem_w_en  output  4/1/1/1  registered control outputs.
REQ-015 status  output  4  registered NZCV flags, bit3 = N.
REQ-016 branch_taken  output  1  combinational copy of b.
REQ-017 branch_addr  output  32  combinational pc + (sign-extended signed_imm_24 << 2).

Function
REQ-018 op1 SHALL be val_rn, mem_fwd_val or wb_fwd_val, chosen by sel_src1.
REQ-019 The forwarded store value SHALL be val_rm, mem_fwd_val or wb_fwd_val, chosen by sel_src2.
REQ-020 The ALU SHALL compute, on op1 and val2 with C the current status carry: MOV=val2; MVN=~val2; ADD=op1+val2; ADC=op1+val2+C; SUB=op1-val2; SBC=op1-val2-~C; AND/ORR/EOR bitwise; any undefined opcode gives 0.
REQ-021 Arithmetic SHALL be 33-bit internally.
REQ-022 C SHALL be the carry out for ADD/ADC and NOT borrow for SUB/SBC; logical ops and MOV/MVN leave C unchanged.
REQ-023 V SHALL be set on signed overflow for ADD/ADC/SUB/SBC; all other ops leave V unchanged.
REQ-024 N SHALL be result[31] and Z SHALL be (result == 0).
REQ-025 On each rising clk with freeze low, the EX/MEM registers SHALL load the ALU result, the store value, dest_in, wb_en_in, mem_r_en_in and mem_w_en_in; latency is one cycle.
REQ-026 status SHALL update on a rising clk only when s_bit=1 and freeze=0; otherwise it holds.
REQ-027 When freeze and s_bit are both high, freeze SHALL win and no register updates.
REQ-028 branch_addr wrap-around SHALL be modulo 2^32.

Reset
REQ-029 Asserting rst SHALL immediately clear alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en and status to 0, independent of clk, including in the middle of a freeze.
REQ-030 When rst releases, the first rising clk SHALL perform a normal load.

Configuration
REQ-031 With FORWARDING_EN defined, operand selection SHALL follow sel_src1/sel_src2 as specified in REQ-018 and REQ-019.
REQ-032 Without FORWARDING_EN, the sel_* and *_fwd_val inputs SHALL be ignored and op1=val_rn, store value=val_rm; the ports remain present.

Structure
REQ-033 A shared package SHALL hold the exe_cmd opcode constants, the forwarding-select encodings and the NZCV bit indices.
REQ-034 The ALU SHALL be a separate combinational sub-module named alu, with inputs op1, val2, exe_cmd and carry-in and outputs result and NZCV.
REQ-035 Operand selection and the EX/MEM registers SHALL stay in exe_stage.

Verification
REQ-036 ADD 0x7FFFFFFF+0x1 with s_bit=1 -> next cycle alu_res=0x80000000, status=1001 (N, V set).
REQ-037 SUB 5-5 with s_bit=1 -> alu_res=0, status=0110 (Z, C set); then the same instruction with s_bit=0 and a different result -> status unchanged.
REQ-038 sel_src1=01 with mem_fwd_val=0x10, sel_src1=10 with wb_fwd_val=0x20, ADD with val2=1 -> alu_res 0x11 then 0x21; without FORWARDING_EN -> val_rn+1.
REQ-039 freeze held high for 3 cycles while the inputs change -> all outputs hold; first cycle after freeze drops -> outputs reflect the current inputs.
REQ-040 b=1, pc=0x100, signed_imm_24=0xFFFFFE -> branch_taken=1, branch_addr=0xF8 in the same cycle.
REQ-041 rst pulsed between clk edges while freeze is high -> all registered outputs read 0 immediately.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding selects, NZCV bit positions.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  // Encoding 11 falls back to the register-file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf_val,
                                          input logic [31:0] mem_val,
                                          input logic [31:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return rf_val;
    endcase
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX-to-EX/MEM bundle: master drives the decoded instruction, slave is the execute stage.
interface exe_stage_if;
  logic        freeze;
  logic [3:0]  exe_cmd;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        s_bit;
  logic        b;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [31:0] val2;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd_val;
  logic [31:0] wb_fwd_val;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [3:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_addr;

  modport master (
    output freeze, exe_cmd, wb_en_in, mem_r_en_in, mem_w_en_in, s_bit, b, pc,
           val_rn, val_rm, val2, signed_imm_24, dest_in, sel_src1, sel_src2,
           mem_fwd_val, wb_fwd_val,
    input  alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en, status,
           branch_taken, branch_addr
  );

  modport slave (
    input  freeze, exe_cmd, wb_en_in, mem_r_en_in, mem_w_en_in, s_bit, b, pc,
           val_rn, val_rm, val2, signed_imm_24, dest_in, sel_src1, sel_src2,
           mem_fwd_val, wb_fwd_val,
    output alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en, status,
           branch_taken, branch_addr
  );
endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU with 33-bit arithmetic; arith_o tells the caller whether C/V are freshly computed.
module alu
  import exe_stage_pkg::*;
(
  input  logic [31:0] op1_i,
  input  logic [31:0] val2_i,
  input  logic [3:0]  exe_cmd_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output logic [3:0]  nzcv_o,
  output logic        arith_o
);

  logic [32:0] sum;
  logic        c_out;
  logic        v_out;

  always_comb begin
    sum      = '0;
    result_o = '0;
    c_out    = carry_i;
    v_out    = 1'b0;
    arith_o  = 1'b0;
    case (exe_cmd_i)
      CMD_MOV: result_o = val2_i;
      CMD_MVN: result_o = ~val2_i;
      CMD_AND: result_o = op1_i & val2_i;
      CMD_ORR: result_o = op1_i | val2_i;
      CMD_EOR: result_o = op1_i ^ val2_i;
      CMD_ADD, CMD_ADC: begin
        sum      = {1'b0, op1_i} + {1'b0, val2_i}
                 + {32'b0, carry_i & (exe_cmd_i == CMD_ADC)};
        result_o = sum[31:0];
        c_out    = sum[32];
        v_out    = (op1_i[31] == val2_i[31]) && (sum[31] != op1_i[31]);
        arith_o  = 1'b1;
      end
      CMD_SUB, CMD_SBC: begin
        // Bit 32 of the 33-bit difference is the borrow; ARM carry is its inverse.
        sum      = {1'b0, op1_i} - {1'b0, val2_i}
                 - {32'b0, ~carry_i & (exe_cmd_i == CMD_SBC)};
        result_o = sum[31:0];
        c_out    = ~sum[32];
        v_out    = (op1_i[31] != val2_i[31]) && (sum[31] != op1_i[31]);
        arith_o  = 1'b1;
      end
      default: result_o = '0;
    endcase
    nzcv_o        = '0;
    nzcv_o[N_IDX] = result_o[31];
    nzcv_o[Z_IDX] = (result_o == 32'd0);
    nzcv_o[C_IDX] = c_out;
    nzcv_o[V_IDX] = v_out;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, NZCV status and EX/MEM pipeline registers.
// Build option: define FORWARDING_EN to honour sel_src1/sel_src2; otherwise register values are used.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  logic [1:0]  sel1;
  logic [1:0]  sel2;
  logic [31:0] op1;
  logic [31:0] st_fwd;
  logic [31:0] alu_result;
  logic [3:0]  alu_nzcv;
  logic        alu_arith;
  logic [3:0]  status_d;

  logic [31:0] alu_res_q;
  logic [31:0] st_val_q;
  logic [3:0]  dest_q;
  logic        wb_en_q;
  logic        mem_r_en_q;
  logic        mem_w_en_q;
  logic [3:0]  status_q;

`ifdef FORWARDING_EN
  assign sel1 = bus.sel_src1;
  assign sel2 = bus.sel_src2;
`else
  logic unused_sel;
  assign unused_sel = ^{bus.sel_src1, bus.sel_src2};
  assign sel1 = FWD_REG;
  assign sel2 = FWD_REG;
`endif

  assign op1    = fwd_mux(sel1, bus.val_rn, bus.mem_fwd_val, bus.wb_fwd_val);
  assign st_fwd = fwd_mux(sel2, bus.val_rm, bus.mem_fwd_val, bus.wb_fwd_val);

  alu u_alu (
    .op1_i     (op1),
    .val2_i    (bus.val2),
    .exe_cmd_i (bus.exe_cmd),
    .carry_i   (status_q[C_IDX]),
    .result_o  (alu_result),
    .nzcv_o    (alu_nzcv),
    .arith_o   (alu_arith)
  );

  // V is only rewritten by arithmetic; C already passes through the ALU for other ops.
  always_comb begin
    status_d = alu_nzcv;
    if (!alu_arith) begin
      status_d[V_IDX] = status_q[V_IDX];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      status_q   <= '0;
    end else if (!bus.freeze) begin
      alu_res_q  <= alu_result;
      st_val_q   <= st_fwd;
      dest_q     <= bus.dest_in;
      wb_en_q    <= bus.wb_en_in;
      mem_r_en_q <= bus.mem_r_en_in;
      mem_w_en_q <= bus.mem_w_en_in;
      if (bus.s_bit) begin
        status_q <= status_d;
      end
    end
  end

  assign bus.alu_res      = alu_res_q;
  assign bus.st_val       = st_val_q;
  assign bus.dest         = dest_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.mem_r_en     = mem_r_en_q;
  assign bus.mem_w_en     = mem_w_en_q;
  assign bus.status       = status_q;
  assign bus.branch_taken = bus.b;
  assign bus.branch_addr  = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed corner cases followed by random instructions
// compared against an arithmetic reference model. Honours FORWARDING_EN like the design.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] m_alu, m_st;
  logic [3:0]  m_dest, m_status;
  logic        m_wb, m_mr, m_mw;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] bv, input logic [3:0] st,
                                  output logic [31:0] res, output logic [3:0] nst);
    longint ua, ub, sa, sb, full, sfull, extra;
    logic c, v;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, bv});
    sa = longint'($signed(a));
    sb = longint'($signed(bv));
    c  = st[1];
    v  = st[0];
    res = 32'd0;
    case (cmd)
      4'b0001: res = bv;
      4'b1001: res = ~bv;
      4'b0110: res = a & bv;
      4'b0111: res = a | bv;
      4'b1000: res = a ^ bv;
      4'b0010, 4'b0011: begin
        extra = (cmd == 4'b0011 && c) ? 1 : 0;
        full  = ua + ub + extra;
        sfull = sa + sb + extra;
        res   = full[31:0];
        c     = (full > 64'sd4294967295);
        v     = (sfull > SMAX) || (sfull < SMIN);
      end
      4'b0100, 4'b0101: begin
        extra = (cmd == 4'b0101 && !c) ? 1 : 0;
        full  = ua - ub - extra;
        sfull = sa - sb - extra;
        res   = full[31:0];
        c     = (ua >= ub + extra);
        v     = (sfull > SMAX) || (sfull < SMIN);
      end
      default: res = 32'd0;
    endcase
    nst = {res[31], (res == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] pick_src(input logic [1:0] sel, input logic [31:0] rf);
`ifdef FORWARDING_EN
    if (sel == 2'b01) return bus.mem_fwd_val;
    if (sel == 2'b10) return bus.wb_fwd_val;
`endif
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_alu_res"},  bus.alu_res, m_alu);
    chk({tag, "_st_val"},   bus.st_val, m_st);
    chk({tag, "_dest"},     {28'd0, bus.dest}, {28'd0, m_dest});
    chk({tag, "_ctrl"},     {29'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en},
                            {29'd0, m_wb, m_mr, m_mw});
    chk({tag, "_status"},   {28'd0, bus.status}, {28'd0, m_status});
  endtask

  task automatic model_reset();
    m_alu = '0; m_st = '0; m_dest = '0; m_status = '0;
    m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
  endtask

  // Check the combinational branch outputs, clock once, advance the model, compare everything.
  task automatic step(input string tag);
    logic [31:0] res, bexp;
    logic [3:0]  nst;
    int off;
    #1;
    off  = $signed(bus.signed_imm_24);
    bexp = bus.pc + 32'(off * 4);
    chk({tag, "_br_taken"}, {31'd0, bus.branch_taken}, {31'd0, bus.b});
    chk({tag, "_br_addr"},  bus.branch_addr, bexp);
    ref_alu(bus.exe_cmd, pick_src(bus.sel_src1, bus.val_rn), bus.val2, m_status, res, nst);
    @(posedge clk);
    #1;
    if (!bus.freeze) begin
      m_alu  = res;
      m_st   = pick_src(bus.sel_src2, bus.val_rm);
      m_dest = bus.dest_in;
      m_wb   = bus.wb_en_in;
      m_mr   = bus.mem_r_en_in;
      m_mw   = bus.mem_w_en_in;
      if (bus.s_bit) m_status = nst;
    end
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_inputs();
    bus.exe_cmd       = 4'($urandom_range(0, 15));
    bus.wb_en_in      = 1'($urandom);
    bus.mem_r_en_in   = 1'($urandom);
    bus.mem_w_en_in   = 1'($urandom);
    bus.s_bit         = 1'($urandom);
    bus.b             = 1'($urandom);
    bus.pc            = $urandom;
    bus.val_rn        = rand_op();
    bus.val_rm        = $urandom;
    bus.val2          = rand_op();
    bus.signed_imm_24 = 24'($urandom);
    bus.dest_in       = 4'($urandom);
    bus.sel_src1      = 2'($urandom);
    bus.sel_src2      = 2'($urandom);
    bus.mem_fwd_val   = $urandom;
    bus.wb_fwd_val    = $urandom;
  endtask

  initial begin
    bus.freeze = 1'b0; bus.exe_cmd = 4'd0; bus.wb_en_in = 1'b0; bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = 1'b0; bus.s_bit = 1'b0; bus.b = 1'b0; bus.pc = '0; bus.val_rn = '0;
    bus.val_rm = '0; bus.val2 = '0; bus.signed_imm_24 = '0; bus.dest_in = '0;
    bus.sel_src1 = '0; bus.sel_src2 = '0; bus.mem_fwd_val = '0; bus.wb_fwd_val = '0;
    model_reset();

    #12;
    check_all("reset");
    rst = 1'b0;

    // Signed overflow on ADD, first cycle out of reset
    bus.exe_cmd = 4'b0010; bus.val_rn = 32'h7FFF_FFFF; bus.val2 = 32'h1; bus.s_bit = 1'b1;
    bus.dest_in = 4'd3; bus.wb_en_in = 1'b1; bus.val_rm = 32'hCAFE_0001;
    step("add_ovf");
    chk("add_ovf_const_res", bus.alu_res, 32'h8000_0000);
    chk("add_ovf_const_nzcv", {28'd0, bus.status}, 32'h9);

    // SUB 5-5 sets Z and C; then s_bit=0 keeps the flags
    bus.exe_cmd = 4'b0100; bus.val_rn = 32'd5; bus.val2 = 32'd5;
    step("sub_zero");
    chk("sub_zero_const_res", bus.alu_res, 32'h0);
    chk("sub_zero_const_nzcv", {28'd0, bus.status}, 32'h6);
    bus.s_bit = 1'b0; bus.val_rn = 32'd9;
    step("sub_nos");
    chk("sub_nos_const_res", bus.alu_res, 32'h4);
    chk("sub_nos_const_nzcv", {28'd0, bus.status}, 32'h6);

    // Forwarding selects
    bus.exe_cmd = 4'b0010; bus.val_rn = 32'h5; bus.val2 = 32'h1;
    bus.mem_fwd_val = 32'h10; bus.wb_fwd_val = 32'h20;
    bus.sel_src1 = 2'b01; bus.sel_src2 = 2'b10;
    step("fwd_mem");
`ifdef FORWARDING_EN
    chk("fwd_mem_const", bus.alu_res, 32'h11);
    chk("fwd_st_wb_const", bus.st_val, 32'h20);
`else
    chk("fwd_mem_const", bus.alu_res, 32'h6);
    chk("fwd_st_wb_const", bus.st_val, bus.val_rm);
`endif
    bus.sel_src1 = 2'b10; bus.sel_src2 = 2'b01;
    step("fwd_wb");
`ifdef FORWARDING_EN
    chk("fwd_wb_const", bus.alu_res, 32'h21);
`else
    chk("fwd_wb_const", bus.alu_res, 32'h6);
`endif
    bus.sel_src1 = 2'b11;
    step("fwd_11");

    // Freeze for three cycles with changing inputs (s_bit forced high too)
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      bus.s_bit = 1'b1;
      step("freeze");
    end
    bus.freeze = 1'b0;
    rand_inputs();
    step("unfreeze");

    // Branch target with a negative offset
    bus.b = 1'b1; bus.pc = 32'h100; bus.signed_imm_24 = 24'hFFFFFE;
    #1;
    chk("branch_taken_const", {31'd0, bus.branch_taken}, 32'h1);
    chk("branch_addr_const", bus.branch_addr, 32'hF8);
    step("branch");

    // Asynchronous reset between edges while frozen, then a normal load
    bus.freeze = 1'b1;
    rand_inputs();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    #1 rst = 1'b0;
    step("rst_frozen_hold");
    bus.freeze = 1'b0;
    rand_inputs();
    bus.s_bit = 1'b1;
    step("rst_first_load");

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      bus.freeze = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
